// File: rtl/wubsuit_clk_lock_monitor_if.sv
// Bundles the monitor's control inputs and status outputs.
// master: the side that enables the monitor and feeds it the watched clock.
// slave:  the monitor itself.
interface wubsuit_clk_lock_monitor_if #(
    parameter int CNT_W = 16
);
    logic             ENABLE;
    logic             MON_CLK;
    logic             FAULT_CLR;
    logic             LOCK;
    logic [CNT_W-1:0] PERIOD;
    logic             PERIOD_VALID;
    logic             FAULT;
    logic [1:0]       STATE;

    modport master (
        output ENABLE, MON_CLK, FAULT_CLR,
        input  LOCK, PERIOD, PERIOD_VALID, FAULT, STATE
    );

    modport slave (
        input  ENABLE, MON_CLK, FAULT_CLR,
        output LOCK, PERIOD, PERIOD_VALID, FAULT, STATE
    );
endinterface

// File: rtl/wubsuit_clk_lock_monitor.sv
// Lock/frequency monitor for a slow clock sampled on FAB_CLK.
// Each MON_CLK period is measured in FAB_CLK cycles. LOCK is given after
// LOCK_COUNT consecutive in-window periods. FAULT is a sticky flag raised
// whenever an established lock is lost, through a bad period or a missing clock.
module wubsuit_clk_lock_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_MIN    = 3000,
    parameter int EXP_MAX    = 3100,
    parameter int TIMEOUT    = 6200,
    parameter int LOCK_COUNT = 4
) (
    input  logic                      FAB_CLK,
    input  logic                      M2F_RESET_N,
    wubsuit_clk_lock_monitor_if.slave bus
);

    localparam int               GC_W      = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(EXP_MAX);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [GC_W-1:0]  LOCK_C    = GC_W'(LOCK_COUNT);

    // The counter must be able to reach TIMEOUT without hitting its
    // saturation value, and the legal window must sit below the timeout.
    if (!(EXP_MIN > 0 && EXP_MIN <= EXP_MAX && EXP_MAX < TIMEOUT &&
          TIMEOUT < (2 ** CNT_W) - 1 && LOCK_COUNT >= 1)) begin : g_param_check
        $error("wubsuit_clk_lock_monitor: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GC_W-1:0]  gc_q, gc_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic             lock_q, lock_d;
    logic             fault_q, fault_d;
    logic             s1_q, s2_q, s3_q;

    logic             rise;
    logic             active;
    logic             timeout;
    logic             edge_seen;
    logic             meas;
    logic             good;
    logic             bad_evt;
    logic [GC_W-1:0]  gc_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign rise      = s2_q & ~s3_q;
    assign active    = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);
    assign timeout   = (cnt_q == TIMEOUT_C) & ~rise;
    assign edge_seen = bus.ENABLE & rise & active;
    assign meas      = edge_seen & armed_q;
    assign good      = (cnt_q >= MIN_C) && (cnt_q <= MAX_C);
    assign bad_evt   = (meas & ~good) | (timeout & active);
    assign gc_inc    = gc_q + 1'b1;

    // Two-flop synchronizer on MON_CLK plus a third flop for edge detection.
    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.MON_CLK;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // State, measurement and status registers.
    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gc_q     <= '0;
            armed_q  <= 1'b0;
            period_q <= '0;
            pv_q     <= 1'b0;
            lock_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gc_q     <= gc_d;
            armed_q  <= armed_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            lock_q   <= lock_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state logic: period counter, measurement capture, FSM and flags.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gc_d     = gc_q;
        armed_d  = armed_q;
        period_d = period_q;
        pv_d     = 1'b0;
        fault_d  = fault_q;

        // The counter restarts at 1 on every edge so its value at the next
        // edge is exactly the period; it is parked at 0 while idle.
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (rise) begin
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = sat_inc(cnt_q);
        end

        // The first edge after leaving IDLE only arms; there is no reference
        // edge yet, so its count is meaningless.
        if (edge_seen) begin
            if (armed_q) begin
                period_d = cnt_q;
                pv_d     = 1'b1;
            end else begin
                armed_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                armed_d = 1'b0;
                gc_d    = '0;
                if (bus.ENABLE) begin
                    state_d = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                if (meas && good) begin
                    gc_d = gc_inc;
                    if (gc_inc == LOCK_C) begin
                        state_d = ST_LOCKED;
                    end
                end else if (bad_evt) begin
                    gc_d = '0;
                end
            end
            ST_LOCKED: begin
                if (bad_evt) begin
                    state_d = ST_LOST;
                end
            end
            ST_LOST: begin
                // armed and cnt carry over so the edge that broke lock
                // becomes the reference for the next measurement.
                state_d = ST_ACQUIRE;
                gc_d    = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (!bus.ENABLE) begin
            state_d = ST_IDLE;
        end

        // A new loss outranks a simultaneous clear so no event is missed.
        if (state_q == ST_LOCKED && state_d == ST_LOST) begin
            fault_d = 1'b1;
        end else if (bus.FAULT_CLR) begin
            fault_d = 1'b0;
        end
    end

    assign lock_d           = (state_d == ST_LOCKED);
    assign bus.LOCK         = lock_q;
    assign bus.PERIOD       = period_q;
    assign bus.PERIOD_VALID = pv_q;
    assign bus.FAULT        = fault_q;
    assign bus.STATE        = state_q;

endmodule

// File: tb/tb_wubsuit_clk_lock_monitor.sv
// Directed bench for wubsuit_clk_lock_monitor with a small period window.
module tb_wubsuit_clk_lock_monitor;

    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n;

    wubsuit_clk_lock_monitor_if #(.CNT_W(CNT_W)) bus ();

    wubsuit_clk_lock_monitor #(
        .CNT_W(CNT_W), .EXP_MIN(20), .EXP_MAX(24), .TIMEOUT(50), .LOCK_COUNT(4)
    ) dut (
        .FAB_CLK(clk),
        .M2F_RESET_N(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // One MON_CLK period of n cycles; expectations refer to the edge that
    // starts the period, which measures the previous entry's n.
    typedef struct {
        int n;
        int clr;
        int pv;
        int per;
        int st;
        int lk;
        int flt;
        int lost;
    } vec_t;

    vec_t tbl [26];

    int n_cmp;
    int n_bad;
    int pv_seen;
    int lost_seen;
    int lost_fault;
    int pv_last;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // clr_mode: 0 = no clear, 1 = one-cycle pulse at start, 2 = hold until LOST seen
    task automatic mon_cycle(input int n, input int clr_mode);
        pv_seen       = 0;
        lost_seen     = 0;
        lost_fault    = -1;
        bus.MON_CLK   = 1'b1;
        bus.FAULT_CLR = (clr_mode != 0);
        for (int i = 0; i < n; i++) begin
            tick();
            if (i + 1 == n / 2) bus.MON_CLK = 1'b0;
            if (clr_mode == 1 && i == 0) bus.FAULT_CLR = 1'b0;
            if (bus.PERIOD_VALID) begin
                pv_seen++;
                pv_last = int'(bus.PERIOD);
            end
            if (bus.STATE == 2'd3) begin
                lost_seen++;
                lost_fault = int'(bus.FAULT);
                if (clr_mode == 2) bus.FAULT_CLR = 1'b0;
            end
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        pv_last       = 0;
        rst_n         = 1'b0;
        bus.ENABLE    = 1'b0;
        bus.MON_CLK   = 1'b0;
        bus.FAULT_CLR = 1'b0;

        //          n  clr pv per st lk flt lost
        tbl[0]  = '{22, 0, 0,  0, 1, 0, 0, 0};
        tbl[1]  = '{22, 0, 1, 22, 1, 0, 0, 0};
        tbl[2]  = '{22, 0, 1, 22, 1, 0, 0, 0};
        tbl[3]  = '{22, 0, 1, 22, 1, 0, 0, 0};
        tbl[4]  = '{22, 0, 1, 22, 2, 1, 0, 0};
        tbl[5]  = '{30, 0, 1, 22, 2, 1, 0, 0};
        tbl[6]  = '{22, 0, 1, 30, 1, 0, 1, 1};
        tbl[7]  = '{22, 0, 1, 22, 1, 0, 1, 0};
        tbl[8]  = '{22, 0, 1, 22, 1, 0, 1, 0};
        tbl[9]  = '{22, 0, 1, 22, 1, 0, 1, 0};
        tbl[10] = '{26, 0, 1, 22, 2, 1, 1, 0};
        tbl[11] = '{22, 0, 1, 26, 1, 0, 1, 1};
        tbl[12] = '{26, 1, 1, 22, 1, 0, 0, 0};
        tbl[13] = '{22, 0, 1, 26, 1, 0, 0, 0};
        tbl[14] = '{26, 0, 1, 22, 1, 0, 0, 0};
        tbl[15] = '{20, 0, 1, 26, 1, 0, 0, 0};
        tbl[16] = '{24, 0, 1, 20, 1, 0, 0, 0};
        tbl[17] = '{25, 0, 1, 24, 1, 0, 0, 0};
        tbl[18] = '{20, 0, 1, 25, 1, 0, 0, 0};
        tbl[19] = '{24, 0, 1, 20, 1, 0, 0, 0};
        tbl[20] = '{19, 0, 1, 24, 1, 0, 0, 0};
        tbl[21] = '{20, 0, 1, 19, 1, 0, 0, 0};
        tbl[22] = '{24, 0, 1, 20, 1, 0, 0, 0};
        tbl[23] = '{22, 0, 1, 24, 1, 0, 0, 0};
        tbl[24] = '{22, 0, 1, 22, 1, 0, 0, 0};
        tbl[25] = '{22, 0, 1, 22, 2, 1, 0, 0};

        // Reset values
        repeat (3) tick();
        chk("rst_lock",   int'(bus.LOCK), 0);
        chk("rst_period", int'(bus.PERIOD), 0);
        chk("rst_pv",     int'(bus.PERIOD_VALID), 0);
        chk("rst_fault",  int'(bus.FAULT), 0);
        chk("rst_state",  int'(bus.STATE), 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_no_enable", int'(bus.STATE), 0);
        bus.ENABLE = 1'b1;
        tick();
        chk("enable_acquire", int'(bus.STATE), 1);

        // Acquire, lock, bad period, relock, alternating and boundary periods
        for (int i = 0; i < 26; i++) begin
            mon_cycle(tbl[i].n, tbl[i].clr);
            chk($sformatf("v%0d_pv_count", i), pv_seen, tbl[i].pv);
            if (tbl[i].pv != 0) chk($sformatf("v%0d_pv_period", i), pv_last, tbl[i].per);
            chk($sformatf("v%0d_period", i), int'(bus.PERIOD), tbl[i].per);
            chk($sformatf("v%0d_state", i), int'(bus.STATE), tbl[i].st);
            chk($sformatf("v%0d_lock", i), int'(bus.LOCK), tbl[i].lk);
            chk($sformatf("v%0d_fault", i), int'(bus.FAULT), tbl[i].flt);
            chk($sformatf("v%0d_lost_cycles", i), lost_seen, tbl[i].lost);
        end

        // Missing clock while locked: one last edge, then MON_CLK stuck low
        bus.MON_CLK = 1'b1;
        pv_seen     = 0;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (k == 11) bus.MON_CLK = 1'b0;
            if (k == 3) chk("t3_last_pv", int'(bus.PERIOD_VALID), 1);
            if (k > 3 && bus.PERIOD_VALID) pv_seen++;
            if (k == 52) begin
                chk("t3_k52_state", int'(bus.STATE), 2);
                chk("t3_k52_lock",  int'(bus.LOCK), 1);
            end
            if (k == 53) begin
                chk("t3_k53_state", int'(bus.STATE), 3);
                chk("t3_k53_lock",  int'(bus.LOCK), 0);
                chk("t3_k53_fault", int'(bus.FAULT), 1);
            end
            if (k == 54) chk("t3_k54_state", int'(bus.STATE), 1);
        end
        chk("t3_no_pv", pv_seen, 0);
        mon_cycle(22, 0);
        chk("t3_sat_pv",     pv_seen, 1);
        chk("t3_sat_period", pv_last, 255);
        chk("t3_sat_state",  int'(bus.STATE), 1);
        for (int j = 0; j < 4; j++) begin
            mon_cycle(22, 0);
            if (j == 2) chk("t3_relock_early", int'(bus.LOCK), 0);
        end
        chk("t3_relock", int'(bus.LOCK), 1);
        chk("t3_fault_kept", int'(bus.FAULT), 1);

        // ENABLE=0 while locked
        bus.ENABLE = 1'b0;
        chk("dis_state_before", int'(bus.STATE), 2);
        tick();
        chk("dis_state",  int'(bus.STATE), 0);
        chk("dis_lock",   int'(bus.LOCK), 0);
        chk("dis_fault",  int'(bus.FAULT), 1);
        chk("dis_period", int'(bus.PERIOD), 22);
        mon_cycle(22, 0);
        chk("dis_no_pv",       pv_seen, 0);
        chk("dis_state_held",  int'(bus.STATE), 0);
        chk("dis_period_held", int'(bus.PERIOD), 22);
        bus.ENABLE = 1'b1;
        tick();
        chk("reen_state", int'(bus.STATE), 1);
        for (int j = 0; j < 5; j++) begin
            mon_cycle(22, 0);
            if (j == 0) chk("reen_first_pv", pv_seen, 0);
            if (j == 3) chk("reen_lock_4th", int'(bus.LOCK), 0);
        end
        chk("reen_lock_5th", int'(bus.LOCK), 1);

        // FAULT_CLR held across the loss: set wins, later clear alone works
        mon_cycle(30, 2);
        chk("clr_pre_fault", int'(bus.FAULT), 0);
        chk("clr_pre_state", int'(bus.STATE), 2);
        mon_cycle(22, 2);
        chk("clr_lost_cycles", lost_seen, 1);
        chk("clr_lost_fault",  lost_fault, 1);
        chk("clr_fault_after", int'(bus.FAULT), 1);
        chk("clr_period",      pv_last, 30);
        mon_cycle(22, 1);
        chk("clr_pulse_fault", int'(bus.FAULT), 0);
        for (int j = 0; j < 3; j++) mon_cycle(22, 0);
        chk("clr_relock", int'(bus.LOCK), 1);

        // One-cycle reset while locked
        rst_n = 1'b0;
        tick();
        chk("mid_rst_lock",   int'(bus.LOCK), 0);
        chk("mid_rst_period", int'(bus.PERIOD), 0);
        chk("mid_rst_pv",     int'(bus.PERIOD_VALID), 0);
        chk("mid_rst_fault",  int'(bus.FAULT), 0);
        chk("mid_rst_state",  int'(bus.STATE), 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_state", int'(bus.STATE), 1);
        for (int j = 0; j < 5; j++) begin
            mon_cycle(22, 0);
            if (j == 0) chk("post_rst_first_pv", pv_seen, 0);
            if (j == 3) chk("post_rst_lock_4th", int'(bus.LOCK), 0);
        end
        chk("post_rst_lock_5th", int'(bus.LOCK), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
